// File: rtl/writeback_arbiter_if.sv
// Write-back arbiter handshake bundle: ALU and long-latency
// producers in, registered register-file write port out.
interface writeback_arbiter_if #(
  parameter int XLEN = 32
);
  logic            i_alu_valid;
  logic            o_alu_ready;
  logic [4:0]      i_alu_rd;
  logic [XLEN-1:0] i_alu_data;
  logic            i_lsu_valid;
  logic            o_lsu_ready;
  logic [4:0]      i_lsu_rd;
  logic [XLEN-1:0] i_lsu_data;
  logic            o_reg_write;
  logic [4:0]      o_rd;
  logic [XLEN-1:0] o_rd_din;

  modport master (
    output i_alu_valid, i_alu_rd, i_alu_data,
    output i_lsu_valid, i_lsu_rd, i_lsu_data,
    input  o_alu_ready, o_lsu_ready,
    input  o_reg_write, o_rd, o_rd_din
  );

  modport slave (
    input  i_alu_valid, i_alu_rd, i_alu_data,
    input  i_lsu_valid, i_lsu_rd, i_lsu_data,
    output o_alu_ready, o_lsu_ready,
    output o_reg_write, o_rd, o_rd_din
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Write-back arbiter: ALU priority, long-latency FIFO with starvation guard.
// Optional pending-write bitmap enabled by macro WB_SCOREBOARD_EN.
module writeback_arbiter #(
  parameter int XLEN         = 32,
  parameter int LQ_DEPTH     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  writeback_arbiter_if.slave wb
`ifdef WB_SCOREBOARD_EN
  ,
  input  logic        i_issue_valid,
  input  logic [4:0]  i_issue_rd,
  output logic [31:0] o_busy
`endif
);

  localparam int AW = $clog2(LQ_DEPTH);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_ent_t;

  wb_ent_t         mem_q [LQ_DEPTH];
  wb_ent_t         mem_d [LQ_DEPTH];
  logic [AW:0]     wptr_q, wptr_d;
  logic [AW:0]     rptr_q, rptr_d;
  logic [3:0]      starve_q, starve_d;
  logic            reg_write_q, reg_write_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] din_q, din_d;

  logic            empty, full, starved;
  logic            alu_take, lq_take, push;
  logic            sel_valid;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;
  wb_ent_t         head;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign starved = (starve_q == LIMIT);
  assign head    = mem_q[rptr_q[AW-1:0]];

  assign alu_take = wb.i_alu_valid && !starved;
  assign lq_take  = !alu_take && !empty;
  assign push     = wb.i_lsu_valid && !full;

  assign wb.o_alu_ready = !starved;
  assign wb.o_lsu_ready = !full;
  assign wb.o_reg_write = reg_write_q;
  assign wb.o_rd        = rd_q;
  assign wb.o_rd_din    = din_q;

  // Pick this cycle's single write-back source.
  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    unique case (1'b1)
      alu_take: begin
        sel_valid = 1'b1;
        sel_rd    = wb.i_alu_rd;
        sel_data  = wb.i_alu_data;
      end
      lq_take: begin
        sel_valid = 1'b1;
        sel_rd    = head.rd;
        sel_data  = head.data;
      end
      default: ;
    endcase
  end

  // Queue storage and pointer advance; head popped only when chosen.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      mem_d[wptr_q[AW-1:0]] = '{rd: wb.i_lsu_rd, data: wb.i_lsu_data};
      wptr_d = wptr_q + PTR_ONE;
    end
    if (lq_take) rptr_d = rptr_q + PTR_ONE;
  end

  // Count cycles the queue head waits; saturates at the limit.
  always_comb begin
    starve_d = starve_q;
    if (empty || lq_take) starve_d = '0;
    else if (starve_q != LIMIT) starve_d = starve_q + 4'd1;
  end

  // Register the write port; rd 0 is consumed silently, idle holds.
  always_comb begin
    reg_write_d = sel_valid && (sel_rd != 5'd0);
    rd_d        = rd_q;
    din_d       = din_q;
    if (reg_write_d) begin
      rd_d  = sel_rd;
      din_d = sel_data;
    end
  end

  // State update; reset drops queued and pending writes at once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < LQ_DEPTH; i++) mem_q[i] <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      starve_q    <= '0;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      din_q       <= '0;
    end else begin
      mem_q       <= mem_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      starve_q    <= starve_d;
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      din_q       <= din_d;
    end
  end

`ifdef WB_SCOREBOARD_EN
  logic [31:0] busy_q, busy_d;

  assign o_busy = busy_q;

  // Pending-write bitmap: issue sets, presented write clears, set wins.
  always_comb begin
    busy_d = busy_q;
    if (reg_write_q) busy_d[rd_q] = 1'b0;
    if (i_issue_valid && (i_issue_rd != 5'd0))
      busy_d[i_issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Bitmap register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed self-checking bench for writeback_arbiter.
// Define WB_SCOREBOARD_EN to also exercise the busy bitmap.
module tb_writeback_arbiter;

  logic i_clk;
  logic i_rst_n;
  int   checks;
  int   failures;

  writeback_arbiter_if #(.XLEN(32)) wb ();

`ifdef WB_SCOREBOARD_EN
  logic        i_issue_valid;
  logic [4:0]  i_issue_rd;
  logic [31:0] o_busy;
`endif

  writeback_arbiter #(
    .XLEN(32),
    .LQ_DEPTH(2),
    .STARVE_LIMIT(4)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .wb(wb)
`ifdef WB_SCOREBOARD_EN
    ,
    .i_issue_valid(i_issue_valid),
    .i_issue_rd(i_issue_rd),
    .o_busy(o_busy)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    i_clk          = 1'b0;
    i_rst_n        = 1'b0;
    wb.i_alu_valid = 1'b0;
    wb.i_alu_rd    = '0;
    wb.i_alu_data  = '0;
    wb.i_lsu_valid = 1'b0;
    wb.i_lsu_rd    = '0;
    wb.i_lsu_data  = '0;
`ifdef WB_SCOREBOARD_EN
    i_issue_valid  = 1'b0;
    i_issue_rd     = '0;
`endif

    // reset values
    #12;
    chk("rst_reg_write", 64'(wb.o_reg_write), 64'd0);
    chk("rst_rd", 64'(wb.o_rd), 64'd0);
    chk("rst_din", 64'(wb.o_rd_din), 64'd0);
    chk("rst_lsu_ready", 64'(wb.o_lsu_ready), 64'd1);
    chk("rst_alu_ready", 64'(wb.o_alu_ready), 64'd1);
`ifdef WB_SCOREBOARD_EN
    chk("rst_busy", 64'(o_busy), 64'd0);
`endif
    i_rst_n = 1'b1;
    tick();

    // single ALU write
    wb.i_alu_valid = 1'b1;
    wb.i_alu_rd    = 5'd5;
    wb.i_alu_data  = 32'h1234;
    chk("alu_ready", 64'(wb.o_alu_ready), 64'd1);
    tick();
    wb.i_alu_valid = 1'b0;
    chk("alu_we", 64'(wb.o_reg_write), 64'd1);
    chk("alu_rd", 64'(wb.o_rd), 64'd5);
    chk("alu_din", 64'(wb.o_rd_din), 64'h1234);
    tick();
    chk("idle_we", 64'(wb.o_reg_write), 64'd0);
    chk("idle_rd_hold", 64'(wb.o_rd), 64'd5);
    chk("idle_din_hold", 64'(wb.o_rd_din), 64'h1234);

    // back-to-back LSU pushes
    wb.i_lsu_valid = 1'b1;
    wb.i_lsu_rd    = 5'd7;
    wb.i_lsu_data  = 32'hA;
    chk("lsu_ready0", 64'(wb.o_lsu_ready), 64'd1);
    tick();
    wb.i_lsu_rd    = 5'd8;
    wb.i_lsu_data  = 32'hB;
    chk("lsu_ready1", 64'(wb.o_lsu_ready), 64'd1);
    chk("lsu_lat_we", 64'(wb.o_reg_write), 64'd0);
    tick();
    wb.i_lsu_valid = 1'b0;
    chk("lsu7_we", 64'(wb.o_reg_write), 64'd1);
    chk("lsu7_rd", 64'(wb.o_rd), 64'd7);
    chk("lsu7_din", 64'(wb.o_rd_din), 64'hA);
    chk("lsu_ready2", 64'(wb.o_lsu_ready), 64'd1);
    tick();
    chk("lsu8_we", 64'(wb.o_reg_write), 64'd1);
    chk("lsu8_rd", 64'(wb.o_rd), 64'd8);
    chk("lsu8_din", 64'(wb.o_rd_din), 64'hB);
    tick();
    chk("lsu_idle_we", 64'(wb.o_reg_write), 64'd0);

    // starvation: ALU every cycle, one LSU entry
    wb.i_alu_valid = 1'b1;
    wb.i_alu_rd    = 5'd1;
    wb.i_lsu_valid = 1'b1;
    wb.i_lsu_rd    = 5'd9;
    wb.i_lsu_data  = 32'h99;
    for (int k = 0; k < 7; k++) begin
      wb.i_alu_data = 32'(k);
      chk($sformatf("stv_alu_ready%0d", k), 64'(wb.o_alu_ready),
          (k == 5) ? 64'd0 : 64'd1);
      tick();
      wb.i_lsu_valid = 1'b0;
      chk($sformatf("stv_rd%0d", k), 64'(wb.o_rd),
          (k == 5) ? 64'd9 : 64'd1);
      chk($sformatf("stv_din%0d", k), 64'(wb.o_rd_din),
          (k == 5) ? 64'h99 : 64'(k));
    end
    wb.i_alu_valid = 1'b0;
    tick();

    // full queue: third push held, order kept
    wb.i_alu_valid = 1'b1;
    wb.i_alu_rd    = 5'd2;
    for (int c = 0; c < 17; c++) begin
      logic [4:0] lrd;
      logic [4:0] erd;
      lrd = (c == 0) ? 5'd10 : ((c == 1) ? 5'd11 : 5'd12);
      wb.i_lsu_valid = (c <= 6);
      wb.i_lsu_rd    = lrd;
      wb.i_lsu_data  = 32'h100 + 32'(lrd);
      wb.i_alu_data  = 32'h200 + 32'(c);
      chk($sformatf("full_alu_ready%0d", c), 64'(wb.o_alu_ready),
          (c == 5 || c == 10 || c == 15) ? 64'd0 : 64'd1);
      chk($sformatf("full_lsu_ready%0d", c), 64'(wb.o_lsu_ready),
          (c <= 1 || c == 6 || c >= 11) ? 64'd1 : 64'd0);
      erd = (c == 5) ? 5'd10 : (c == 10) ? 5'd11 :
            (c == 15) ? 5'd12 : 5'd2;
      tick();
      chk($sformatf("full_we%0d", c), 64'(wb.o_reg_write), 64'd1);
      chk($sformatf("full_rd%0d", c), 64'(wb.o_rd), 64'(erd));
      chk($sformatf("full_din%0d", c), 64'(wb.o_rd_din),
          (erd == 5'd2) ? 64'h200 + 64'(c) : 64'h100 + 64'(erd));
    end
    wb.i_lsu_valid = 1'b0;

    // rd 0 consumed silently
    wb.i_alu_rd   = 5'd0;
    wb.i_alu_data = 32'hFFFF;
    tick();
    wb.i_alu_valid = 1'b0;
    chk("rd0_we", 64'(wb.o_reg_write), 64'd0);
    chk("rd0_rd_hold", 64'(wb.o_rd), 64'd2);
    chk("rd0_din_hold", 64'(wb.o_rd_din), 64'h210);
`ifdef WB_SCOREBOARD_EN
    chk("rd0_busy", 64'(o_busy), 64'd0);
`endif

    // asynchronous reset mid-operation
    wb.i_lsu_valid = 1'b1;
    wb.i_lsu_rd    = 5'd13;
    wb.i_lsu_data  = 32'hD;
    tick();
    wb.i_lsu_valid = 1'b0;
    wb.i_alu_valid = 1'b1;
    wb.i_alu_rd    = 5'd4;
    wb.i_alu_data  = 32'h44;
    tick();
    wb.i_alu_valid = 1'b0;
    chk("pre_rst_we", 64'(wb.o_reg_write), 64'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst_we", 64'(wb.o_reg_write), 64'd0);
    chk("arst_rd", 64'(wb.o_rd), 64'd0);
    chk("arst_din", 64'(wb.o_rd_din), 64'd0);
    chk("arst_lsu_ready", 64'(wb.o_lsu_ready), 64'd1);
    i_rst_n = 1'b1;
    tick();
    chk("arst_drop_we", 64'(wb.o_reg_write), 64'd0);
    tick();
    chk("arst_drop_we2", 64'(wb.o_reg_write), 64'd0);

`ifdef WB_SCOREBOARD_EN
    // pending-write bitmap
    i_issue_valid = 1'b1;
    i_issue_rd    = 5'd3;
    tick();
    i_issue_valid = 1'b0;
    chk("sb_set", 64'(o_busy), 64'h8);
    wb.i_alu_valid = 1'b1;
    wb.i_alu_rd    = 5'd3;
    wb.i_alu_data  = 32'h33;
    tick();
    wb.i_alu_valid = 1'b0;
    chk("sb_we", 64'(wb.o_reg_write), 64'd1);
    chk("sb_hold", 64'(o_busy), 64'h8);
    i_issue_valid = 1'b1;
    tick();
    i_issue_valid = 1'b0;
    chk("sb_set_wins", 64'(o_busy), 64'h8);
    wb.i_alu_valid = 1'b1;
    tick();
    wb.i_alu_valid = 1'b0;
    chk("sb_pending", 64'(o_busy), 64'h8);
    tick();
    chk("sb_clear", 64'(o_busy), 64'd0);
    i_issue_valid = 1'b1;
    i_issue_rd    = 5'd0;
    tick();
    i_issue_valid = 1'b0;
    chk("sb_rd0", 64'(o_busy), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter XLEN, 32, data width of write-back results.
REQ-002 Parameter LQ_DEPTH, 2, long-latency queue depth in entries (power of 2, ≥2).
REQ-003 Parameter STARVE_LIMIT, 4, consecutive blocked cycles before the ALU is stalled (1..15).
REQ-004 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 i_rst_n  input  1  asynchronous active-low reset.
REQ-006 i_alu_valid  input  1  ALU result offered this cycle.
REQ-007 o_alu_ready  output  1  ALU result accepted when i_alu_valid && o_alu_ready.
REQ-008 i_alu_rd / i_alu_data  input  5 / XLEN  ALU destination register and result.
REQ-009 i_lsu_valid  input  1  long-latency (load/mul) result offered.
REQ-010 o_lsu_ready  output  1  long-latency result accepted into queue when i_lsu_valid && o_lsu_ready.
REQ-011 i_lsu_rd / i_lsu_data  input  5 / XLEN  long-latency destination and result.
REQ-012 o_reg_write / o_rd / o_rd_din  output  1 / 5 / XLEN  registered write port driving the register file's i_reg_write / i_rd / i_rd_din.

Function
REQ-013 o_lsu_ready SHALL equal !full of the LQ_DEPTH-entry FIFO; no same-cycle push-on-full even when a pop occurs.
REQ-014 Each cycle exactly one source SHALL be selected: accepted ALU result if present, else FIFO head if non-empty, else none.
REQ-015 o_alu_ready SHALL be 1 except when the starvation counter equals STARVE_LIMIT, in which cycle it SHALL be 0 and the FIFO head SHALL be selected.
REQ-016 Starvation counter SHALL increment each cycle the FIFO is non-empty and the head is not selected, clear when the head is selected or the FIFO is empty, and saturate at STARVE_LIMIT.
REQ-017 The selected result SHALL appear on o_rd/o_rd_din with o_reg_write=1 exactly one cycle after selection; ALU latency 1 cycle, long-latency minimum 2 cycles (enqueue, then pop).
REQ-018 A selected entry with rd==0 SHALL be consumed (popped/accepted) but o_reg_write SHALL be 0 for that cycle.
REQ-019 With no selection, o_reg_write SHALL be 0; o_rd/o_rd_din SHALL hold their previous values.
REQ-020 FIFO SHALL preserve arrival order; read/write pointers wrap modulo LQ_DEPTH with an extra bit distinguishing full from empty.
REQ-021 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave occupancy unchanged; push to an empty FIFO SHALL NOT be poppable the same cycle.

Reset
REQ-022 While i_rst_n=0: o_reg_write=0, o_rd=0, o_rd_din=0, FIFO empty (o_lsu_ready=1), starvation counter=0, o_alu_ready=1.
REQ-023 Reset asserted mid-operation SHALL discard all queued entries and any pending output write immediately, without waiting for a clock edge.

Configuration
REQ-024 Macro WB_SCOREBOARD_EN defined: add ports i_issue_valid (input, 1), i_issue_rd (input, 5), o_busy (output, 32) maintaining a pending-write bitmap.
REQ-025 With WB_SCOREBOARD_EN: busy[i_issue_rd] set on i_issue_valid (ignored for rd 0); busy[o_rd] cleared on the edge after o_reg_write=1 is presented; set wins over clear to the same register in the same cycle; o_busy resets to 0; o_busy[0] is always 0.
REQ-026 Without WB_SCOREBOARD_EN: those ports and the bitmap SHALL NOT exist; all other behaviour is identical.

Verification
REQ-027 ALU valid rd=5 data=0x1234 one cycle, FIFO empty -> next cycle o_reg_write=1, o_rd=5, o_rd_din=0x1234.
REQ-028 LSU push rd=7 data=0xA, rd=8 data=0xB on back-to-back cycles, no ALU -> writes rd 7 then 8 on consecutive cycles, first 2 cycles after its push; o_lsu_ready never drops.
REQ-029 ALU valid every cycle, LSU push rd=9 -> o_alu_ready=0 exactly on the 5th cycle after the push (STARVE_LIMIT=4 blocked cycles), rd=9 written the following cycle, ALU resumes.
REQ-030 Three LSU pushes with ALU continuously valid -> o_lsu_ready=0 after second push; third held until a pop; order preserved.
REQ-031 ALU valid rd=0 data=0xFFFF -> o_reg_write stays 0; no scoreboard change.
REQ-032 WB_SCOREBOARD_EN: issue rd=3, then ALU rd=3 -> o_busy[3]=1 until the edge after the write; issue rd=3 coinciding with that clear -> o_busy[3] stays 1.
